// File: rtl/mult_arb.sv
// Round-robin arbiter sharing one pipelined multiplier among R requesters; LAT+2 cycles handshake->rsp_valid.
// Grants stop under flush or !en; responses have no backpressure and return in issue order.
module mult_arb #(
  parameter int N   = 4,
  parameter int M   = 4,
  parameter int R   = 4,
  parameter int LAT = M
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [R-1:0]     req_valid,
  input  logic [R*N-1:0]   req_a,
  input  logic [R*M-1:0]   req_b,
  output logic [R-1:0]     req_ready,
  output logic             mul_data_ready,
  output logic [N-1:0]     mul_mult1,
  output logic [M-1:0]     mul_mult2,
  input  logic             mul_result_ready,
  input  logic [N+M-1:0]   mul_result,
  output logic [R-1:0]     rsp_valid,
  output logic [N+M-1:0]   rsp_data,
  output logic             flush_done,
  output logic             busy,
  output logic             err
);
  localparam int IW = (R > 1) ? $clog2(R) : 1;
  localparam int CW = $clog2(LAT + 3);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] idx;
  } tag_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  tag_t [LAT:0]    tag_q, tag_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic            mul_data_ready_q, mul_data_ready_d;
  logic [N-1:0]    mul_mult1_q, mul_mult1_d;
  logic [M-1:0]    mul_mult2_q, mul_mult2_d;
  logic [R-1:0]    rsp_valid_q, rsp_valid_d;
  logic [N+M-1:0]  rsp_data_q, rsp_data_d;
  logic            flush_done_q, flush_done_d;
  logic            err_q, err_d;

  logic            grant_en;
  logic            any_vld;
  logic [R-1:0]    gnt;
  logic [IW-1:0]   gnt_idx;
  logic            hs;
  tag_t            out_tag;
  logic            rsp_fire;
  int              cand;

  // Arbiter: walk offsets high to low so the lowest offset from ptr wins.
  always_comb begin
    grant_en = (state_q == RUN) && en && !flush;
    any_vld  = 1'b0;
    gnt_idx  = '0;
    gnt      = '0;
    cand     = 0;
    for (int k = R - 1; k >= 0; k--) begin
      cand = (int'(ptr_q) + k) % R;
      if (req_valid[cand]) begin
        gnt_idx = IW'(cand);
        any_vld = 1'b1;
      end
    end
    if (grant_en && any_vld) gnt = {{(R-1){1'b0}}, 1'b1} << gnt_idx;
  end

  assign hs = |gnt;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en && !flush) state_d = RUN;
      RUN: begin
        if (flush)                          state_d = DRAIN;
        else if (!en && inflight_q == '0)   state_d = IDLE;
      end
      DRAIN:   if (inflight_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flush_done_d = ((state_q == IDLE) && flush) ||
                   ((state_q == DRAIN) && (inflight_q == '0));
  end

  always_comb begin
    ptr_d            = hs ? IW'((int'(gnt_idx) + 1) % R) : ptr_q;
    mul_data_ready_d = hs;
    mul_mult1_d      = hs ? req_a[int'(gnt_idx)*N +: N] : mul_mult1_q;
    mul_mult2_d      = hs ? req_b[int'(gnt_idx)*M +: M] : mul_mult2_q;

    tag_d[0].vld = hs;
    tag_d[0].idx = gnt_idx;
    for (int k = 1; k <= LAT; k++) tag_d[k] = tag_q[k-1];

    out_tag     = tag_q[LAT];
    rsp_fire    = mul_result_ready && out_tag.vld;
    rsp_valid_d = rsp_fire ? ({{(R-1){1'b0}}, 1'b1} << out_tag.idx) : '0;
    rsp_data_d  = rsp_fire ? mul_result : rsp_data_q;
    err_d       = err_q | (mul_result_ready != out_tag.vld);

    // Retire on tag exit so an orphaned slot can never wedge the counter.
    inflight_d = inflight_q;
    if (hs && !out_tag.vld)      inflight_d = inflight_q + CW'(1);
    else if (!hs && out_tag.vld) inflight_d = inflight_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      ptr_q            <= '0;
      tag_q            <= '0;
      inflight_q       <= '0;
      mul_data_ready_q <= 1'b0;
      mul_mult1_q      <= '0;
      mul_mult2_q      <= '0;
      rsp_valid_q      <= '0;
      rsp_data_q       <= '0;
      flush_done_q     <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      tag_q            <= tag_d;
      inflight_q       <= inflight_d;
      mul_data_ready_q <= mul_data_ready_d;
      mul_mult1_q      <= mul_mult1_d;
      mul_mult2_q      <= mul_mult2_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_data_q       <= rsp_data_d;
      flush_done_q     <= flush_done_d;
      err_q            <= err_d;
    end
  end

  assign req_ready      = gnt;
  assign mul_data_ready = mul_data_ready_q;
  assign mul_mult1      = mul_mult1_q;
  assign mul_mult2      = mul_mult2_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign flush_done     = flush_done_q;
  assign busy           = (inflight_q != '0);
  assign err            = err_q;

endmodule

// File: doc/mult_arb.md
MULT_ARB -- requirements
Module: mult_arb

Interface
REQ-001 Parameter N, default 4, mult1 operand width.
REQ-002 Parameter M, default 4, mult2 operand width.
REQ-003 Parameter R, default 4, requester count (2..8).
REQ-004 Parameter LAT, default M, multiplier latency: cycles from mul_data_ready sampled to mul_result_ready.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 en  in  1  permits leaving IDLE.
REQ-008 flush  in  1  request to stop issuing and drain.
REQ-009 req_valid  in  R  per-requester operand valid.
REQ-010 req_a  in  R*N  requester i operand a at bits [i*N +: N].
REQ-011 req_b  in  R*M  requester i operand b at bits [i*M +: M].
REQ-012 req_ready  out  R  one-hot-or-zero grant; transfer when req_valid[i] & req_ready[i].
REQ-013 mul_data_ready  out  1  issue strobe to multiplier, registered.
REQ-014 mul_mult1  out  N, and mul_mult2  out  M: issued operands, registered.
REQ-015 mul_result_ready  in  1, and mul_result  in  N+M: multiplier output.
REQ-016 rsp_valid  out  R  one-hot pulse, result for requester i, registered.
REQ-017 rsp_data  out  N+M  shared result bus, valid with rsp_valid.
REQ-018 flush_done  out  1  one-cycle pulse, drain complete.
REQ-019 busy  out  1  high when in-flight count nonzero.
REQ-020 err  out  1  sticky tag/result mismatch flag.

Function
REQ-021 FSM states IDLE, RUN, DRAIN; reset state IDLE.
REQ-022 IDLE->RUN when en=1 and flush=0; IDLE with flush=1 -> stays IDLE, flush_done pulses next cycle.
REQ-023 RUN->DRAIN when flush=1; RUN->IDLE when en=0 and in-flight=0.
REQ-024 DRAIN->IDLE when in-flight=0 and no issue pending; flush_done=1 on that transition cycle only.
REQ-025 req_ready all zero unless state RUN and flush=0 and en=1 (flush wins over same-cycle handshake).
REQ-026 Round-robin: grant lowest index i with req_valid[i], searching from pointer ptr upward modulo R; req_ready combinational from req_valid and ptr.
REQ-027 ptr resets to 0; after handshake on i, ptr = (i+1) mod R; unchanged otherwise.
REQ-028 Max one handshake per cycle; no stall required; back-to-back issues every cycle allowed.
REQ-029 Handshake at cycle T: mul_data_ready=1 with latched req_a/req_b slice at T+1; 0 otherwise; operands hold last value when idle.
REQ-030 Tag pipeline LAT+1 stages shifts each cycle, carrying {valid, requester index}; entry inserted at handshake.
REQ-031 When mul_result_ready=1: rsp_valid[tag]=1 and rsp_data=mul_result next cycle; end-to-end latency handshake->rsp_valid = LAT+2.
REQ-032 mul_result_ready with tag invalid, or valid tag without mul_result_ready, sets err; rsp_valid not asserted for orphan results.
REQ-033 In-flight counter: +1 on handshake, -1 on rsp_valid issue, both same cycle -> unchanged; range 0..LAT+2.
REQ-034 Results delivered strictly in issue order; rsp has no backpressure.

Reset
REQ-035 rst=1 at edge: state IDLE, ptr=0, tag pipe cleared, in-flight=0, err=0.
REQ-036 Outputs after reset: req_ready=0, mul_data_ready=0, mul_mult1=0, mul_mult2=0, rsp_valid=0, rsp_data=0, flush_done=0, busy=0.
REQ-037 Reset mid-operation discards all in-flight results; no rsp_valid for pre-reset issues.

Verification
REQ-038 N=M=4, LAT=4: en=1, req0 a=3 b=5 single -> rsp_valid=0001, rsp_data=15, 6 cycles after handshake.
REQ-039 All four req_valid held high from reset -> grants 0,1,2,3,0 on consecutive cycles; responses same order, one per cycle.
REQ-040 req1 a=15 b=15 then flush next cycle -> req_ready=0 from flush cycle; rsp_data=225 to req1; flush_done one pulse after rsp, state IDLE.
REQ-041 flush and req_valid[2] high same cycle in RUN -> no handshake, no issue, flush_done after drain.
REQ-042 Inject mul_result_ready with empty tag pipe -> err=1 held until rst; no rsp_valid.
REQ-043 rst=1 with 3 in flight -> all outputs zero next cycle; no later rsp_valid.
